sha_msg_sched_v2: RTL
=====================

Name: sha_msg_sched_v2

Overview:
Parametrised SHA-2 message scheduler. Accepts one 16-word block through a valid/ready handshake and streams W0..W(NR-1), one word per cycle, to the compression round engine.
Supports SHA-256 (32-bit words, NR=64) and SHA-384/512 (64-bit words, NR=80), selected per block.
Adds an internal round counter, consumer stall, abort and a done pulse.
Sits between the block buffer and the SHA round datapath in the crypto subsystem.

Parameters:
SHA512_SUPPORT, 1, 1 gives 64-bit lanes and both modes; 0 gives 32-bit lanes and SHA-256 only (hash_size ignored).
LW, (SHA512_SUPPORT ? 64 : 32), lane width; derived, not overridden.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
blk_valid  in  1  block offered
blk_ready  out  1  scheduler idle, can accept
blk_data  in  16*LW  16 lanes; lane i = bits [16*LW-1-i*LW -: LW]; lane 0 = W0
hash_size  in  2  bit1=1 selects SHA-384/512, else SHA-256; sampled on accept
stall  in  1  consumer hold; freezes schedule
abort  in  1  synchronous cancel of current block
w_valid  out  1  w_out/w_idx valid
w_out  out  LW  current schedule word Wt
w_idx  out  7  round index t of w_out
done  out  1  one-cycle pulse after final word consumed

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all 16 window regs and counter cleared. Outputs: w_valid=0, w_out=0, w_idx=0, done=0, blk_ready=1 (combinational from IDLE).
- States: IDLE, RUN. blk_ready = (state==IDLE).
- IDLE→RUN: on blk_valid&blk_ready&!abort. Load 16 lanes, latch mode, t=0. Next cycle: w_valid=1, w_out=W0, w_idx=0 (1-cycle load latency).
- SHA-256 mode: each word uses the low 32 bits of its lane; upper lane bits ignored; w_out[63:32]=0 when LW=64.
- RUN advance (stall=0): shift window; the new tail word is computed as Wt = σ1(Wt-2) + Wt-7 + σ0(Wt-15) + Wt-16, modulo 2^32 or 2^64 per mode.
  - SHA-256: σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - SHA-512: σ0 = ROTR1^ROTR8^SHR7; σ1 = ROTR19^ROTR61^SHR6.
  - w_idx increments by 1.
- stall=1 in RUN: window, counter and w_out are held; w_valid stays 1. The consumer takes a word on each cycle with w_valid&!stall.
- Final word: when w_idx=NR-1 (63 or 79) is taken with stall=0, the next cycle is IDLE with done=1 and w_valid=0. done lasts exactly one cycle. blk_ready=1 in that same cycle.
  - A new block can be accepted in the done cycle, giving a 1-cycle bubble between blocks.
- abort=1: highest priority in any state.
  - Next cycle: IDLE, w_valid=0, done=0, w_idx=0.
  - abort in IDLE with blk_valid: block is not accepted.
  - abort overrides stall.
- blk_valid in RUN is ignored (blk_ready=0). hash_size changes in RUN are ignored.
- rst asserted mid-block: immediate return to reset values; no done.
- Counter never wraps: RUN always exits at NR-1.

Optional Feature:
SHA_SCHED_ZEROIZE_EN
- Defined: on the cycle that enters IDLE (from completion or abort), all 16 window regs are cleared to 0, and w_out reads 0 whenever in IDLE. This prevents message residue after a hash.
- Undefined: the window retains its last contents in IDLE and w_out shows the stale tail word, with w_valid=0.

Test Plan:
1. SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), hash_size=00, no stall -> w_idx 0..63 over 64 consecutive cycles, W16=0x61626380, W17=0x000F0000. done one cycle after idx 63; blk_ready=1 that cycle.
2. SHA-512 "abc" (W0=0x6162638000000000, W15=0x18), hash_size=10 -> 80 words, W16=0x6162638000000000, W17=0x00030000000000C0, done after idx 79.
3. Stall held 5 cycles at w_idx=20 (SHA-256 "abc") -> w_out/w_idx frozen for 5 cycles, w_valid=1. Full sequence identical to test 1, completing 5 cycles later.
4. abort at w_idx=30 -> next cycle IDLE, w_valid=0, done never asserted, blk_ready=1. The next block then schedules correctly from idx 0.
5. Back-to-back blocks with blk_valid held high -> second accepted in the done cycle, W0 of the second block appears one cycle later. blk_valid while in RUN is ignored.
6. rst pulsed low at w_idx=40 -> all outputs at reset values asynchronously. With SHA_SCHED_ZEROIZE_EN, w_out=0 after completion; without it, w_out equals the stale tail word.

Source files
------------

// File: rtl/sha_msg_sched_v2_if.sv
// rtl/sha_msg_sched_v2_if.sv - block-in / schedule-word-out bundle for the SHA-2 message scheduler
interface sha_msg_sched_v2_if #(
  parameter int LW = 64
);
  logic              blk_valid;
  logic              blk_ready;
  logic [16*LW-1:0]  blk_data;
  logic [1:0]        hash_size;
  logic              stall;
  logic              abort;
  logic              w_valid;
  logic [LW-1:0]     w_out;
  logic [6:0]        w_idx;
  logic              done;

  modport master (
    output blk_valid, blk_data, hash_size, stall, abort,
    input  blk_ready, w_valid, w_out, w_idx, done
  );

  modport slave (
    input  blk_valid, blk_data, hash_size, stall, abort,
    output blk_ready, w_valid, w_out, w_idx, done
  );
endinterface

// File: rtl/sha_msg_sched_v2.sv
// rtl/sha_msg_sched_v2.sv - SHA-256/384/512 message scheduler streaming W0..W(NR-1)
// Optional macro SHA_SCHED_ZEROIZE_EN clears the window on entering IDLE and forces w_out=0 in IDLE.
module sha_msg_sched_v2 #(
  parameter  int SHA512_SUPPORT = 1,
  localparam int LW = (SHA512_SUPPORT != 0) ? 64 : 32
) (
  input  logic              clk,
  input  logic              rst,
  sha_msg_sched_v2_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [LW-1:0] LOW32 = LW'(32'hFFFF_FFFF);

  state_t        state, state_nxt;
  logic [LW-1:0] win [16];
  logic [LW-1:0] lane_in [16];
  logic [LW-1:0] w_new;
  logic [31:0]   n32;
  logic [6:0]    t_q;
  logic [6:0]    last_idx;
  logic          mode512;
  logic          load_512;
  logic          done_q;
  logic          unused_hash_lsb;

  function automatic logic [31:0] sig0_256(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1_256(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [63:0] sig0_512(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
  endfunction

  function automatic logic [63:0] sig1_512(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
  endfunction

  assign unused_hash_lsb = bus.hash_size[0];
  assign last_idx        = mode512 ? 7'd79 : 7'd63;
  assign load_512        = (SHA512_SUPPORT != 0) && bus.hash_size[1];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      lane_in[i] = bus.blk_data[16*LW-1-i*LW -: LW];
    end
  end

  // win[0] is the word on w_out; win[15] is Wt+15, so the next tail is Wt+16.
  assign n32 = sig1_256(win[14][31:0]) + win[9][31:0] + sig0_256(win[1][31:0]) + win[0][31:0];

  generate
    if (LW == 64) begin : g_w64
      logic [63:0] n64;
      assign n64   = sig1_512(win[14]) + win[9] + sig0_512(win[1]) + win[0];
      assign w_new = mode512 ? n64 : {32'b0, n32};
    end else begin : g_w32
      assign w_new = n32;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.blk_valid) state_nxt = RUN;
        RUN:     if (!bus.stall && (t_q == last_idx)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.blk_ready = (state == IDLE);
    bus.w_valid   = (state == RUN);
    bus.w_idx     = t_q;
    bus.done      = done_q;
`ifdef SHA_SCHED_ZEROIZE_EN
    bus.w_out     = (state == RUN) ? win[0] : '0;
`else
    bus.w_out     = win[0];
`endif
  end

  // The final word is not shifted out, so without zeroize the window keeps W(NR-1) at its head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      t_q     <= '0;
      mode512 <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        t_q <= '0;
`ifdef SHA_SCHED_ZEROIZE_EN
        for (int i = 0; i < 16; i++) win[i] <= '0;
`endif
      end else if (state == IDLE) begin
        if (bus.blk_valid) begin
          for (int i = 0; i < 16; i++) begin
            win[i] <= load_512 ? lane_in[i] : (lane_in[i] & LOW32);
          end
          mode512 <= load_512;
          t_q     <= '0;
        end
      end else if (!bus.stall) begin
        if (t_q == last_idx) begin
          done_q <= 1'b1;
          t_q    <= '0;
`ifdef SHA_SCHED_ZEROIZE_EN
          for (int i = 0; i < 16; i++) win[i] <= '0;
`endif
        end else begin
          for (int i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15] <= w_new;
          t_q     <= t_q + 7'd1;
        end
      end
    end
  end

endmodule
